// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD comb reads with write bypass, two write ports, busy scoreboard, post-reset clear.
// Reads 0 cycles, writes/scoreboard 1 cycle; no backpressure, ready_o low while clearing. Macro RF_PARITY_EN adds parity.
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  parameter int NUM_RD  = 2,
  localparam int AW     = $clog2(REG_NUM)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     ready_o,
  input  logic                     wa_we_i,
  input  logic [AW-1:0]            wa_addr_i,
  input  logic [DATA_W-1:0]        wa_data_i,
  input  logic                     wb_we_i,
  input  logic [AW-1:0]            wb_addr_i,
  input  logic [DATA_W-1:0]        wb_data_i,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*AW-1:0]     rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     sb_set_i,
  input  logic [AW-1:0]            sb_set_addr_i,
  output logic [REG_NUM-1:0]       busy_o,
`ifdef RF_PARITY_EN
  input  logic                     par_inject_i,
`endif
  output logic [NUM_RD-1:0]        par_err_o
);

  typedef enum logic [0:0] {S_CLEAR, S_RUN} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(REG_NUM - 1);

  state_t              r_state;
  logic [AW-1:0]       r_cnt;
  logic                r_ready;
  logic [REG_NUM-1:0]  r_busy;
  logic [DATA_W-1:0]   r_mem [REG_NUM];

  logic                w_wa_ok;
  logic                w_wb_ok;
  logic [REG_NUM-1:0]  w_busy_nxt;

  assign ready_o = r_ready;
  assign busy_o  = r_busy;

  // Entry 0 is never read from the array, so the sweep starts at 1.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_CLEAR;
      r_cnt   <= AW'(1);
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == LAST_IDX) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_CLEAR;
        end
      endcase
    end
  end

  assign w_wa_ok = r_ready & wa_we_i & (wa_addr_i != '0);
  assign w_wb_ok = r_ready & wb_we_i & (wb_addr_i != '0);

`ifdef RF_PARITY_EN
  logic r_par [REG_NUM];
`endif

  // B is written after A so a same-address collision keeps B's data.
  always_ff @(posedge clk_i) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
`ifdef RF_PARITY_EN
      r_par[r_cnt] <= 1'b0;
`endif
    end else begin
      if (w_wa_ok) begin
        r_mem[wa_addr_i] <= wa_data_i;
`ifdef RF_PARITY_EN
        r_par[wa_addr_i] <= (^wa_data_i) ^ par_inject_i;
`endif
      end
      if (w_wb_ok) begin
        r_mem[wb_addr_i] <= wb_data_i;
`ifdef RF_PARITY_EN
        r_par[wb_addr_i] <= ^wb_data_i;
`endif
      end
    end
  end

  // Set is applied last so an issue that lands with a writeback keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wa_ok) begin
      w_busy_nxt[wa_addr_i] = 1'b0;
    end
    if (w_wb_ok) begin
      w_busy_nxt[wb_addr_i] = 1'b0;
    end
    if (sb_set_i) begin
      w_busy_nxt[sb_set_addr_i] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_busy <= '0;
    end else if (r_ready) begin
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_zero;
    logic          w_byp_a;
    logic          w_byp_b;

    assign w_ra    = rd_addr_i[k*AW +: AW];
    assign w_zero  = ~r_ready | (w_ra == '0);
    assign w_byp_b = rd_en_i[k] & wb_we_i & (wb_addr_i == w_ra);
    assign w_byp_a = rd_en_i[k] & wa_we_i & (wa_addr_i == w_ra);

    assign rd_data_o[k*DATA_W +: DATA_W] = w_zero  ? '0        :
                                           w_byp_b ? wb_data_i :
                                           w_byp_a ? wa_data_i :
                                                     r_mem[w_ra];
    assign rd_busy_o[k] = r_ready & r_busy[w_ra];

`ifdef RF_PARITY_EN
    assign par_err_o[k] = ~w_zero & ~w_byp_a & ~w_byp_b & ((^r_mem[w_ra]) ^ r_par[w_ra]);
`endif
  end

`ifndef RF_PARITY_EN
  assign par_err_o = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear timing, bypass, write collisions, scoreboard, optional parity.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int RN = 32;
  localparam int NR = 2;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ready;
  logic              wa_we, wb_we, sb_set;
  logic [AW-1:0]     wa_addr, wb_addr, sb_addr;
  logic [DW-1:0]     wa_data, wb_data;
  logic [NR-1:0]     rd_en, rd_busy, par_err;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [RN-1:0]     busy;
  logic              par_inject;
  logic [DW-1:0]     r0, r1;

  int n_chk, n_pass, n_fail, lat;

  assign r0 = rd_data[DW-1:0];
  assign r1 = rd_data[2*DW-1:DW];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .REG_NUM(RN), .NUM_RD(NR)) dut (
    .clk_i(clk), .rst_i(rst_n), .ready_o(ready),
    .wa_we_i(wa_we), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .sb_set_i(sb_set), .sb_set_addr_i(sb_addr), .busy_o(busy),
`ifdef RF_PARITY_EN
    .par_inject_i(par_inject),
`endif
    .par_err_o(par_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wa_we = 0; wb_we = 0; sb_set = 0;
    wa_addr = '0; wb_addr = '0; sb_addr = '0;
    wa_data = '0; wb_data = '0; par_inject = 0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a, input logic en);
    rd_addr[k*AW +: AW] = a;
    rd_en[k] = en;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst_n = 1'b0;
    idle();
    rd_en = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);

    // First clear: ready rises on the 32nd edge after release.
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (ready) begin lat = i; break; end
    end
    check("clr_lat1", lat, 32);

    // Restart a clear, then interrupt it at cycle 10.
    @(negedge clk); rst_n = 1'b0; #1;
    check("async_ready_drop", ready, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    check("midclr_ready", ready, 0);
    @(negedge clk); rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin
        wa_we = 1; wa_addr = 5'd4; wa_data = 32'h1234;
        set_rd(0, 5'd4, 1'b1);
      end
      if (i == 6) begin
        check("clr_rd_forced", r0, 0);
        check("clr_rd_busy", rd_busy, 0);
      end
      if (i == 20) wa_we = 0;
      if (ready) begin lat = i; break; end
    end
    check("clr_lat2", lat, 32);

    @(negedge clk);
    for (int a = 0; a < RN; a++) begin
      set_rd(0, AW'(a), 1'b1);
      set_rd(1, AW'(RN - 1 - a), 1'b1);
      #1;
      check("clr_rd0", r0, 0);
      check("clr_rd1", r1, 0);
    end
    check("clr_busy", busy, 0);
    check("clr_par", par_err, 0);

    // Bypass on port 0 only (port 1 read enable low).
    @(negedge clk);
    wa_we = 1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
    set_rd(0, 5'd5, 1'b1); set_rd(1, 5'd5, 1'b0); #1;
    check("byp_en", r0, 32'hDEADBEEF);
    check("byp_dis", r1, 0);
    @(negedge clk); idle(); #1;
    check("wr_a_p0", r0, 32'hDEADBEEF);
    check("wr_a_p1", r1, 32'hDEADBEEF);

    // A and B collide on address 7: B wins.
    @(negedge clk);
    wa_we = 1; wa_addr = 5'd7; wa_data = 32'h11;
    wb_we = 1; wb_addr = 5'd7; wb_data = 32'h22;
    set_rd(0, 5'd7, 1'b1); set_rd(1, 5'd7, 1'b0); #1;
    check("coll_byp", r0, 32'h22);
    check("coll_nobyp", r1, 0);
    @(negedge clk); idle(); #1;
    check("coll_st0", r0, 32'h22);
    check("coll_st1", r1, 32'h22);

    // Independent A and B writes on different addresses.
    @(negedge clk);
    wa_we = 1; wa_addr = 5'd8; wa_data = 32'hAA;
    wb_we = 1; wb_addr = 5'd9; wb_data = 32'hBB;
    set_rd(0, 5'd8, 1'b1); set_rd(1, 5'd9, 1'b1); #1;
    check("dual_byp_a", r0, 32'hAA);
    check("dual_byp_b", r1, 32'hBB);
    @(negedge clk); idle(); #1;
    check("dual_st_a", r0, 32'hAA);
    check("dual_st_b", r1, 32'hBB);

    // Address 0 stays zero.
    @(negedge clk);
    wa_we = 1; wa_addr = 5'd0; wa_data = 32'hFFFF;
    wb_we = 1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    set_rd(0, 5'd0, 1'b1); set_rd(1, 5'd0, 1'b0); #1;
    check("r0_byp", r0, 0);
    @(negedge clk); idle(); #1;
    check("r0_st0", r0, 0);
    check("r0_st1", r1, 0);

    // Scoreboard set, set-beats-clear, write clears.
    @(negedge clk);
    sb_set = 1; sb_addr = 5'd3;
    set_rd(0, 5'd3, 1'b1); set_rd(1, 5'd5, 1'b1); #1;
    check("sb_not_yet", busy, 0);
    @(negedge clk); idle(); #1;
    check("sb_set_vec", busy, 32'h0000_0008);
    check("sb_rd_busy", rd_busy, 2'b01);
    @(negedge clk);
    wb_we = 1; wb_addr = 5'd3; wb_data = 32'h33;
    sb_set = 1; sb_addr = 5'd3; #1;
    check("sb_no_byp", rd_busy, 2'b01);
    @(negedge clk); idle(); #1;
    check("sb_set_wins", busy, 32'h0000_0008);
    check("sb_data", r0, 32'h33);
    @(negedge clk);
    wb_we = 1; wb_addr = 5'd3; wb_data = 32'h44;
    @(negedge clk); idle(); #1;
    check("sb_clr_b", busy, 0);
    check("sb_clr_rd", rd_busy, 0);
    @(negedge clk);
    sb_set = 1; sb_addr = 5'd6;
    @(negedge clk);
    sb_set = 1; sb_addr = 5'd0;
    wa_we = 1; wa_addr = 5'd6; wa_data = 32'h66;
    @(negedge clk); idle(); #1;
    check("sb_clr_a_zero", busy, 0);

`ifdef RF_PARITY_EN
    @(negedge clk);
    wa_we = 1; wa_addr = 5'd9; wa_data = 32'h1; par_inject = 1;
    set_rd(0, 5'd9, 1'b1); set_rd(1, 5'd0, 1'b1); #1;
    check("par_byp", par_err, 0);
    @(negedge clk); idle(); #1;
    check("par_inj", par_err, 2'b01);
    @(negedge clk);
    wa_we = 1; wa_addr = 5'd9; wa_data = 32'h1; par_inject = 0;
    @(negedge clk); idle(); #1;
    check("par_ok", par_err, 0);
    check("par_data", r0, 32'h1);
`else
    check("par_tied", par_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
